pipelined_rca_adder: RTL and testbench
======================================

Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder. Successor to the single-bit full adder cell.
- Splits a WIDTH-bit add into STAGES carry-chained slices, with one register boundary per slice.
- Valid/ready handshake on both sides, so it drops into streaming datapaths and bounds the critical path to one slice of ripple carry.
- Feeds the timing-analysis flow: the per-slice carry chain is the measured path.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES; WIDTH >= 2.
- STAGES, 4, number of pipeline slices and latency in cycles; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- in_valid  input  1  a/b/cin valid this cycle.
- in_ready  output  1  adder accepts input this cycle.
- sum  output  WIDTH  result, valid when out_valid.
- cout  output  1  carry-out of bit WIDTH-1.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset is synchronous: sampled on rising clk while rst_n=0.
  - All stage valid bits clear; sum=0, cout=0, out_valid=0.
  - in_ready=1 combinationally in the first cycle after rst_n rises.
- Reset mid-operation discards all in-flight results; no partial output is emitted.
- Slicing:
  - SLICE = WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of a and b, plus the carry registered by stage k-1 (stage 0 uses cin).
  - Each slice is a ripple chain of full-adder cells.
- Operand skew: the upper operand slices not yet consumed, and the lower sum slices already produced, travel with the token in per-stage registers.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready.
  - Whole pipeline holds every register (global enable = !stall).
  - in_ready = !stall.
- Bubbles (stage valid=0) advance normally; no bubble collapsing.
- Latency: an accepted input at cycle N appears with out_valid=1 at cycle N+STAGES, absent stalls.
- Throughput: one result per cycle while out_ready=1.
- Stability: sum/cout/out_valid hold stable while out_valid=1 and out_ready=0.
- Arithmetic: {cout,sum} = a + b + cin, unsigned and exact modulo 2^(WIDTH+1).
  - Wrap-around: all-ones + all-ones + 1 gives sum=all-ones, cout=1.
- Simultaneous events:
  - An input accepted in the same cycle an output drains is legal; the pipeline shifts.
  - in_valid with in_ready=0: the input is not taken; the upstream must hold it.
- STAGES=1 degenerates to a registered adder with latency 1.
- Ordering: results emerge in acceptance order; no reordering, no drops, no duplicates.

Optional Feature:
- Macro: PIPELINED_RCA_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow = carry into MSB XOR cout, aligned with sum.
  - ovf resets to 0, holds during stall, and follows the same valid and stall rules as sum.
- Undefined: no ovf port and no overflow logic; behaviour is otherwise identical.

Test Plan:
- Reset and latency (WIDTH=16, STAGES=4):
  - Assert rst_n=0 for 2 cycles -> out_valid=0, sum=0, cout=0, in_ready=1.
  - Then send a=0x1234, b=0x0FF1, cin=0 -> exactly 4 cycles later sum=0x2225, cout=0, out_valid=1.
- Carry across every slice: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
  - With OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Back-to-back stream: 8 consecutive inputs a=i, b=0x00FF*i, cin=i[0] for i=1..8, out_ready=1 -> 8 consecutive results in order starting cycle 4, in_ready held 1.
- Backpressure:
  - Stream 6 items, drop out_ready for 3 cycles after the first result -> sum/cout stable, in_ready=0 during the stall.
  - On release, results resume in order with none lost or duplicated.
- Reset mid-flight: accept 3 inputs, then pulse rst_n=0 for 1 cycle -> out_valid stays 0 for the next 4 cycles; a new input afterwards yields a correct result.
- Degenerate config STAGES=1, WIDTH=8: a=0xAB, b=0x55, cin=1 -> next cycle sum=0x01, cout=1; randomised 1000 vectors match a+b+cin.

Source files
------------

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: {cout,sum} = a + b + cin, split into STAGES carry-chained slices.
// Latency STAGES cycles from input transfer to out_valid; one result per cycle when unstalled.
// Backpressure: a held output (out_valid && !out_ready) freezes every stage and drops in_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   a, b, cin            operands and carry-in, qualified by in_valid; in_ready = !stall
//   sum, cout            result, qualified by out_valid; consumed when out_ready
//   ovf                  signed overflow, aligned with sum (only with PIPELINED_RCA_ADDER_OVF_EN)
//
// Constraints: WIDTH must be a multiple of STAGES, WIDTH >= 2, 1 <= STAGES <= WIDTH.
// Optional feature macro: PIPELINED_RCA_ADDER_OVF_EN.

module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
`ifdef PIPELINED_RCA_ADDER_OVF_EN
  output logic             ovf,
`endif
  input  logic             out_ready
);

  localparam int SLICE = WIDTH / STAGES;

  // One slice of full-adder cells rippling from bit 0 upward.
  // Returns {carry_out, sum_slice}.
  function automatic logic [SLICE:0] rca_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    logic             c;
    logic [SLICE-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < SLICE; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // Global enable: the whole pipeline freezes while the output is held.
  logic stall;
  logic en;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;

  // Each stage consumes the low slice of the operands it receives, forwards the
  // still-unconsumed upper operand bits, and appends its sum slice above the
  // sum slices produced by earlier stages. Register widths therefore differ per
  // stage: operands shrink by SLICE bits, the partial sum grows by SLICE bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM  = WIDTH - k * SLICE;   // operand bits still to be added
    localparam int DONE = (k + 1) * SLICE;     // sum bits known after this stage

    logic [REM-1:0]  a_in;
    logic [REM-1:0]  b_in;
    logic            c_in;
    logic            v_in;
    logic [SLICE:0]  res;
    logic [DONE-1:0] s_next;

    logic            v_q;
    logic            c_q;
    logic [DONE-1:0] s_q;

    assign res = rca_slice(a_in[SLICE-1:0], b_in[SLICE-1:0], c_in);

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b;
      assign c_in   = cin;
      assign v_in   = in_valid;
      assign s_next = res[SLICE-1:0];
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {res[SLICE-1:0], g_stage[k-1].s_q};
    end

    // Data registers only load on a real token so a bubble leaves the last
    // result on sum/cout instead of garbage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= res[SLICE];
          s_q <= s_next;
        end
      end
    end

    // Upper operand slices skewed forward with the token; absent in the last stage.
    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SLICE-1:0] a_q;
      logic [REM-SLICE-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && v_in) begin
          a_q <= a_in[REM-1:SLICE];
          b_q <= b_in[REM-1:SLICE];
        end
      end
    end

`ifdef PIPELINED_RCA_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit (s = x ^ y ^ c),
    // so overflow = c_msb ^ cout without exposing the internal carry.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en && v_in) begin
          ovf_q <= res[SLICE] ^ res[SLICE-1] ^ a_in[SLICE-1] ^ b_in[SLICE-1];
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign sum       = g_stage[STAGES-1].s_q;

`ifdef PIPELINED_RCA_ADDER_OVF_EN
  assign ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Testbench for pipelined_rca_adder: 16-bit/4-stage instance plus 8-bit/1-stage instance.
// Directed vector table, streaming, backpressure and mid-flight reset sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled there as well.

module tb_pipelined_rca_adder;

  logic        clk;
  logic        rst_n;

  // 16-bit, 4-stage instance
  logic [15:0] a, b, sum;
  logic        cin, in_valid, in_ready, cout, out_valid, out_ready;
`ifdef PIPELINED_RCA_ADDER_OVF_EN
  logic        ovf;
`endif

  // 8-bit, 1-stage instance
  logic [7:0]  a8, b8, sum8;
  logic        cin8, in_valid8, in_ready8, cout8, out_valid8, out_ready8;
`ifdef PIPELINED_RCA_ADDER_OVF_EN
  logic        ovf8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        tbl[8];
  logic [17:0] exp_q[$];   // {ovf, cout, sum}

  pipelined_rca_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .out_valid(out_valid),
`ifdef PIPELINED_RCA_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .out_ready(out_ready)
  );

  pipelined_rca_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .sum(sum8), .cout(cout8), .out_valid(out_valid8),
`ifdef PIPELINED_RCA_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .out_ready(out_ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic        o;
    t = {1'b0, x} + {1'b0, y} + {16'd0, c};
    o = (x[15] == y[15]) && (t[15] != x[15]);
    return {o, t};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // One isolated vector through an empty pipeline: valid exactly 4 cycles later.
  task automatic single(input vec_t v, input string nm);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, in_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      if (c < 4) check({nm, "_early_valid"}, out_valid, 0);
    end
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_sum"}, sum, v.sum);
    check({nm, "_cout"}, cout, v.cout);
`ifdef PIPELINED_RCA_ADDER_OVF_EN
    check({nm, "_ovf"}, ovf, v.ovf);
`endif
    @(posedge clk); #1;
    check({nm, "_drained"}, out_valid, 0);
  endtask

  // Stream n items; optionally hold the first result for stall_len cycles.
  task automatic stream(input int n, input int stall_len, input int mode);
    int          idx, got, cyc, stalled, first_cyc, gaps;
    bit          first_seen;
    logic [15:0] hs;
    logic        hc;
    logic [17:0] e;
    idx = 0; got = 0; cyc = 0; stalled = 0; first_cyc = -1; gaps = 0;
    first_seen = 1'b0; hs = '0; hc = 1'b0;
    while (got < n && cyc < 200) begin
      in_valid = (idx < n);
      if (mode == 0) begin
        a   = 16'(idx + 1);
        b   = 16'(32'h00FF * (idx + 1));
        cin = 1'(idx + 1);
      end else begin
        a   = 16'(32'h1357 * (idx + 1));
        b   = 16'hF0F0;
        cin = 1'(idx);
      end
      if (out_valid && !first_seen) begin
        first_seen = 1'b1; first_cyc = cyc; hs = sum; hc = cout;
      end
      out_ready = !(first_seen && stalled < stall_len);
      #1;
      if (!out_ready) begin
        check("stall_sum", sum, hs);
        check("stall_cout", cout, hc);
        check("stall_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        stalled++;
      end else if (stall_len == 0) begin
        check("b2b_in_ready", in_ready, 1);
      end
      if (stall_len == 0 && first_seen && !out_valid) gaps++;
      if (in_valid && in_ready) begin
        exp_q.push_back(model16(a, b, cin));
        idx++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("res_sum", sum, e[15:0]);
          check("res_cout", cout, e[16]);
`ifdef PIPELINED_RCA_ADDER_OVF_EN
          check("res_ovf", ovf, e[17]);
`endif
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (got < n) fail_now("stream_timeout");
    if (stall_len == 0) begin
      check("b2b_first_cycle", first_cyc, 4);
      check("b2b_gaps", gaps, 0);
    end else begin
      check("stall_cycles", stalled, stall_len);
    end
    #1;
    check("drain_out_valid", out_valid, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    logic [8:0] t8;
    logic       o8;

    tbl[0] = '{16'h1234, 16'h0FF1, 1'b0, 16'h2225, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid8", out_valid8, 0);
`ifdef PIPELINED_RCA_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed table, one vector at a time
    for (int i = 0; i < 8; i++) single(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back stream of 8, then backpressure stream of 6
    stream(8, 0, 0);
    stream(6, 3, 1);

    // Reset mid-flight: 3 accepted, 1-cycle reset, nothing emerges
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(32'h0100 * (i + 1)); b = 16'h0011; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 0);
    end
    single(tbl[2], "post_midrst");

    // STAGES=1, WIDTH=8: registered adder, latency 1
    a8 = 8'hAB; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("d8_valid", out_valid8, 1);
    check("d8_sum", sum8, 8'h01);
    check("d8_cout", cout8, 1);
    @(posedge clk); #1;
    check("d8_bubble", out_valid8, 0);

    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      in_valid8 = 1'b1;
      t8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      o8 = (a8[7] == b8[7]) && (t8[7] != a8[7]);
      @(posedge clk); #1;
      check("d8_rand", {out_valid8, cout8, sum8}, {1'b1, t8});
`ifdef PIPELINED_RCA_ADDER_OVF_EN
      check("d8_rand_ovf", ovf8, o8);
`else
      if (o8 === 1'bx) fail_now("d8_model_x");
`endif
    end
    in_valid8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
